// File: rtl/rb_window_sched_if.sv
// rb_window_sched_if: pixel, window and row-buffer signals of the window scheduler
// Ports (modports):
//   master  scheduler side: drives pix_ready, win_valid/win_row/win_col,
//           rb_wr_en/rb_wr_addr/rb_wr_sel, rb_rd_en/rb_rd_addr, steer;
//           samples pix_valid, win_ready
//   slave   environment side: drives pix_valid, win_ready; samples the rest
interface rb_window_sched_if #(
    parameter int IMG_W = 8,
    parameter int IMG_H = 8,
    parameter int K     = 3
);
    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);
    localparam int SW = (K > 2) ? $clog2(K - 1) : 1;

    logic          pix_valid;
    logic          pix_ready;
    logic          win_valid;
    logic          win_ready;
    logic [RW-1:0] win_row;
    logic [CW-1:0] win_col;
    logic          rb_wr_en;
    logic [CW-1:0] rb_wr_addr;
    logic [SW-1:0] rb_wr_sel;
    logic          rb_rd_en;
    logic [CW-1:0] rb_rd_addr;
    logic [SW-1:0] steer;

    modport master (
        input  pix_valid, win_ready,
        output pix_ready, win_valid, win_row, win_col,
               rb_wr_en, rb_wr_addr, rb_wr_sel, rb_rd_en, rb_rd_addr, steer
    );

    modport slave (
        output pix_valid, win_ready,
        input  pix_ready, win_valid, win_row, win_col,
               rb_wr_en, rb_wr_addr, rb_wr_sel, rb_rd_en, rb_rd_addr, steer
    );
endinterface

// File: rtl/rb_window_sched.sv
// rb_window_sched: row-buffer and KxK window scheduler for a raster pixel stream
// Ports:
//   clk         clock, all state changes on the rising edge
//   rst_n       asynchronous active-low reset
//   start       frame start pulse, honoured only in IDLE
//   busy        high in every state other than IDLE
//   frame_done  one-cycle pulse after the last window has been handed off
//   bus         rb_window_sched_if.master: pixel handshake, window handshake,
//               row-buffer strobes/addresses and the window-mux steer index
// Configuration: define RB_AUTO_RESTART_EN to re-enter FILL straight after
//   frame_done (continuous streaming) instead of returning to IDLE.
module rb_window_sched #(
    parameter int IMG_W = 8,
    parameter int IMG_H = 8,
    parameter int K     = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic              busy,
    output logic              frame_done,
    rb_window_sched_if.master bus
);
    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);
    localparam int SW = (K > 2) ? $clog2(K - 1) : 1;
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [CW-1:0] COL_K    = CW'(K - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
    localparam logic [RW-1:0] ROW_K    = RW'(K - 1);
    localparam logic [RW-1:0] ROW_FILL = RW'(K - 2);
    localparam logic [SW-1:0] STR_LAST = SW'(K - 2);

    typedef enum logic [1:0] {IDLE, FILL, RUN, DONE} state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] col;
    logic [RW-1:0] row;
    logic [SW-1:0] steer;
    logic          acc, col_end, clr;

    // A pending window that is not taken stalls the pixel stream so the
    // row buffers are never overwritten under a window still in use.
    assign bus.pix_ready  = (state == FILL || state == RUN) && !(bus.win_valid && !bus.win_ready);
    assign acc            = bus.pix_valid && bus.pix_ready;
    assign col_end        = col == COL_LAST;
    assign bus.rb_wr_en   = acc;
    assign bus.rb_rd_en   = acc;
    assign bus.rb_wr_addr = col;
    assign bus.rb_rd_addr = col;
    assign bus.rb_wr_sel  = steer;
    assign bus.steer      = steer;
    assign busy           = state != IDLE;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // DONE holds until the final window is consumed, then pulses frame_done.
    always_comb begin
        state_nxt  = state;
        clr        = 1'b0;
        frame_done = 1'b0;
        case (state)
            IDLE: if (start) begin
                state_nxt = FILL;
                clr       = 1'b1;
            end
            FILL: if (acc && col_end && row == ROW_FILL) state_nxt = RUN;
            RUN:  if (acc && col_end && row == ROW_LAST) state_nxt = DONE;
            DONE: if (!bus.win_valid) begin
                frame_done = 1'b1;
`ifdef RB_AUTO_RESTART_EN
                state_nxt  = FILL;
                clr        = 1'b1;
`else
                state_nxt  = IDLE;
`endif
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Raster position of the next pixel; steer names the buffer holding the
    // oldest row, which is the one overwritten by the incoming row.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col   <= '0;
            row   <= '0;
            steer <= '0;
        end else if (clr) begin
            col   <= '0;
            row   <= '0;
            steer <= '0;
        end else if (acc) begin
            col <= col_end ? '0 : col + 1'b1;
            if (col_end) begin
                row   <= row + 1'b1;
                steer <= (steer == STR_LAST) ? '0 : steer + 1'b1;
            end
        end
    end

    // A pixel at (r,c) completes the window whose top-left is (r-K+1, c-K+1).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.win_valid <= 1'b0;
            bus.win_row   <= '0;
            bus.win_col   <= '0;
        end else if (state == RUN && acc && col >= COL_K) begin
            bus.win_valid <= 1'b1;
            bus.win_row   <= row - ROW_K;
            bus.win_col   <= col - COL_K;
        end else if (bus.win_ready) begin
            bus.win_valid <= 1'b0;
        end
    end
endmodule
